// File: rtl/lcd_page_scanner_pkg.sv
// Shared definitions for the LCD page scanner: switch decode, 7-segment
// encoding and the derived display geometry.
package lcd_scan_pkg;

   // Low four switch bits; the packed order puts auto_mode on SWI[0].
   typedef struct packed {
      logic dir_down;
      logic freeze;
      logic step;
      logic auto_mode;
   } swi_ctl_t;

   function automatic logic [6:0] seg7(input logic [3:0] nib);
      logic [6:0] code;
      case (nib)
         4'h0:    code = 7'h3F;
         4'h1:    code = 7'h06;
         4'h2:    code = 7'h5B;
         4'h3:    code = 7'h4F;
         4'h4:    code = 7'h66;
         4'h5:    code = 7'h6D;
         4'h6:    code = 7'h7D;
         4'h7:    code = 7'h07;
         4'h8:    code = 7'h7F;
         4'h9:    code = 7'h6F;
         4'hA:    code = 7'h77;
         4'hB:    code = 7'h7C;
         4'hC:    code = 7'h39;
         4'hD:    code = 7'h5E;
         4'hE:    code = 7'h79;
         default: code = 7'h71;
      endcase
      return code;
   endfunction

   function automatic int calc_rpl(input int nbits, input int nbits_lcd);
      return nbits_lcd / nbits;
   endfunction

   function automatic int calc_npages(input int nregs, input int rpp);
      return (nregs + rpp - 1) / rpp;
   endfunction

   function automatic int calc_pbits(input int npages);
      return (npages <= 2) ? 1 : $clog2(npages);
   endfunction

   function automatic int calc_dbits(input int div);
      return (div <= 2) ? 1 : $clog2(div);
   endfunction

endpackage

// File: rtl/lcd_page_scanner_if.sv
// Control bundle between the scanner top and its page counter.
// No valid/ready here: every signal is a level sampled on each clock edge,
// and page is the registered page index, stable between edges.
interface lcd_scan_ctl_if #(
   parameter int PBITS = 1
);
   logic             auto_mode;
   logic             step_lvl;
   logic             dir_down;
   logic [PBITS-1:0] page;

   modport master (
      output auto_mode,
      output step_lvl,
      output dir_down,
      input  page
   );

   modport slave (
      input  auto_mode,
      input  step_lvl,
      input  dir_down,
      output page
   );
endinterface

// File: rtl/lcd_page_scanner_page_ctr.sv
// Page counter: auto-scroll divider, manual step edge detect and an
// up/down counter that wraps over NPAGES pages.
module page_ctr
   import lcd_scan_pkg::*;
#(
   parameter int NPAGES     = 2,
   parameter int PBITS      = 1,
   parameter int SCROLL_DIV = 16
) (
   input logic           clk,
   input logic           rst,
   lcd_scan_ctl_if.slave ctl
);

   localparam int               DBITS     = calc_dbits(SCROLL_DIV);
   localparam logic [DBITS-1:0] DIV_LAST  = DBITS'(SCROLL_DIV - 1);
   localparam logic [PBITS-1:0] PAGE_LAST = PBITS'(NPAGES - 1);

   logic [DBITS-1:0] div_q, div_d;
   logic             prev_q, prev_d;
   logic [PBITS-1:0] page_q, page_d;
   logic             terminal;
   logic             step;
   logic             advance;

   always_comb begin
      terminal = ctl.auto_mode && (div_q == DIV_LAST);
      step     = ctl.step_lvl && !prev_q && !ctl.auto_mode;
      advance  = step || terminal;
      prev_d   = ctl.step_lvl;

      // Manual mode parks the divider at 0 so auto always starts a full period.
      div_d = '0;
      if (ctl.auto_mode && !terminal) begin
         div_d = div_q + DBITS'(1);
      end

      page_d = page_q;
      if (advance) begin
         if (NPAGES == 1) begin
            page_d = '0;
         end else if (ctl.dir_down) begin
            page_d = (page_q == '0) ? PAGE_LAST : page_q - PBITS'(1);
         end else begin
            page_d = (page_q == PAGE_LAST) ? '0 : page_q + PBITS'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q  <= '0;
         prev_q <= 1'b0;
         page_q <= '0;
      end else begin
         div_q  <= div_d;
         prev_q <= prev_d;
         page_q <= page_d;
      end
   end

   assign ctl.page = page_q;

endmodule

// File: rtl/lcd_page_scanner.sv
// Register-page display engine: snapshots the register file and shows it
// page by page on two LCD lines plus LED/7-segment status.
module lcd_page_scanner
   import lcd_scan_pkg::*;
#(
   parameter int NBITS      = 8,
   parameter int NREGS      = 32,
   parameter int NBITS_LCD  = 64,
   parameter int SCROLL_DIV = 16
) (
   input  logic                 clk_2,
   input  logic                 reset,
   input  logic [NBITS-1:0]     SWI,
   input  logic [NBITS-1:0]     regs_in [0:NREGS-1],
   output logic [NBITS-1:0]     LED,
   output logic [7:0]           SEG,
   output logic [NBITS_LCD-1:0] lcd_a,
   output logic [NBITS_LCD-1:0] lcd_b
);

   localparam int RPL    = calc_rpl(NBITS, NBITS_LCD);
   localparam int RPP    = 2 * RPL;
   localparam int NPAGES = calc_npages(NREGS, RPP);
   localparam int PBITS  = calc_pbits(NPAGES);
   localparam int NSLOTS = NPAGES * RPP;
   localparam int IBITS  = $clog2(NSLOTS);

   swi_ctl_t             sw;
   logic                 unused_swi;
   logic [PBITS-1:0]     page;
   logic [IBITS-1:0]     base;

   logic [NBITS-1:0]     snap_q [0:NREGS-1];
   logic [NBITS-1:0]     snap_d [0:NREGS-1];
   logic [NBITS-1:0]     slot   [0:NSLOTS-1];

   logic [NBITS-1:0]     led_q, led_d;
   logic [7:0]           seg_q, seg_d;
   logic [NBITS_LCD-1:0] lcd_a_q, lcd_a_d;
   logic [NBITS_LCD-1:0] lcd_b_q, lcd_b_d;

   assign sw         = swi_ctl_t'(SWI[3:0]);
   assign unused_swi = ^SWI;

   lcd_scan_ctl_if #(.PBITS(PBITS)) ctl_bus ();

   assign ctl_bus.auto_mode = sw.auto_mode;
   assign ctl_bus.step_lvl  = sw.step;
   assign ctl_bus.dir_down  = sw.dir_down;
   assign page              = ctl_bus.page;

   page_ctr #(
      .NPAGES     (NPAGES),
      .PBITS      (PBITS),
      .SCROLL_DIV (SCROLL_DIV)
   ) u_page_ctr (
      .clk (clk_2),
      .rst (reset),
      .ctl (ctl_bus.slave)
   );

   always_comb begin
      for (int i = 0; i < NREGS; i++) begin
         snap_d[i] = sw.freeze ? snap_q[i] : regs_in[i];
      end
   end

   // Pad the snapshot to whole pages so slots past NREGS read as zero.
   always_comb begin
      for (int i = 0; i < NSLOTS; i++) begin
         slot[i] = '0;
      end
      for (int i = 0; i < NREGS; i++) begin
         slot[i] = snap_q[i];
      end
   end

   always_comb begin
      base    = IBITS'(page) * IBITS'(RPP);
      lcd_a_d = '0;
      lcd_b_d = '0;
      for (int k = 0; k < RPL; k++) begin
         lcd_a_d[NBITS*(RPL-1-k) +: NBITS] = slot[base + IBITS'(k)];
         lcd_b_d[NBITS*(RPL-1-k) +: NBITS] = slot[base + IBITS'(RPL + k)];
      end

      led_d                 = '0;
      led_d[PBITS-1:0]      = page;
      led_d[NBITS-1]        = sw.auto_mode;
      led_d[NBITS-2]        = sw.freeze;

      seg_d = {sw.freeze, seg7(4'(page))};
   end

   always_ff @(posedge clk_2) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            snap_q[i] <= '0;
         end
         led_q   <= '0;
         seg_q   <= '0;
         lcd_a_q <= '0;
         lcd_b_q <= '0;
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            snap_q[i] <= snap_d[i];
         end
         led_q   <= led_d;
         seg_q   <= seg_d;
         lcd_a_q <= lcd_a_d;
         lcd_b_q <= lcd_b_d;
      end
   end

   assign LED   = led_q;
   assign SEG   = seg_q;
   assign lcd_a = lcd_a_q;
   assign lcd_b = lcd_b_q;

endmodule

// File: tb/tb_lcd_page_scanner.sv
// Bench for lcd_page_scanner: a 32-register and a 20-register instance share
// stimulus; a reference model feeds an expected queue checked every edge.
module tb_lcd_page_scanner;

   localparam int NBITS      = 8;
   localparam int NREGS      = 32;
   localparam int NREGS2     = 20;
   localparam int NBITS_LCD  = 64;
   localparam int SCROLL_DIV = 16;
   localparam int RPL        = NBITS_LCD / NBITS;
   localparam int RPP        = 2 * RPL;
   localparam int NPAGES     = 2;
   localparam int W          = 2 * NBITS + 2 * NBITS_LCD;

   logic                 clk_2 = 1'b0;
   logic                 reset;
   logic [NBITS-1:0]     SWI;
   logic [NBITS-1:0]     regs  [0:NREGS-1];
   logic [NBITS-1:0]     regs2 [0:NREGS2-1];
   logic [NBITS-1:0]     led1, led2;
   logic [7:0]           seg1, seg2;
   logic [NBITS_LCD-1:0] lcd_a1, lcd_b1, lcd_a2, lcd_b2;

   logic [2*W-1:0]       exp_q [$];
   int                   total = 0;
   int                   bad   = 0;
   bit                   running = 1'b0;

   int                   m_page;
   int                   m_run;
   logic                 m_prev;
   logic [NBITS-1:0]     m_snap [0:NREGS-1];
   logic [6:0]           seg_tab [0:15];

   always #5 clk_2 = ~clk_2;

   always_comb begin
      for (int i = 0; i < NREGS2; i++) regs2[i] = regs[i];
   end

   lcd_page_scanner #(
      .NBITS(NBITS), .NREGS(NREGS), .NBITS_LCD(NBITS_LCD), .SCROLL_DIV(SCROLL_DIV)
   ) dut (
      .clk_2(clk_2), .reset(reset), .SWI(SWI), .regs_in(regs),
      .LED(led1), .SEG(seg1), .lcd_a(lcd_a1), .lcd_b(lcd_b1)
   );

   lcd_page_scanner #(
      .NBITS(NBITS), .NREGS(NREGS2), .NBITS_LCD(NBITS_LCD), .SCROLL_DIV(SCROLL_DIV)
   ) dut20 (
      .clk_2(clk_2), .reset(reset), .SWI(SWI), .regs_in(regs2),
      .LED(led2), .SEG(seg2), .lcd_a(lcd_a2), .lcd_b(lcd_b2)
   );

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Display of the model's current page/snapshot for a file of nregs registers.
   function automatic logic [W-1:0] model_view(input int nregs);
      logic [63:0] a;
      logic [63:0] b;
      logic [7:0]  led;
      logic [7:0]  seg;
      int          base;
      base = m_page * RPP;
      a = '0;
      b = '0;
      for (int k = 0; k < RPL; k++) begin
         a = {a[55:0], (base + k < nregs) ? m_snap[base + k] : 8'h00};
         b = {b[55:0], (base + RPL + k < nregs) ? m_snap[base + RPL + k] : 8'h00};
      end
      led = {SWI[0], SWI[2], 6'(m_page)};
      seg = {SWI[2], seg_tab[m_page[3:0]]};
      return reset ? '0 : {led, seg, a, b};
   endfunction

   task automatic model_edge();
      logic step;
      logic adv;
      exp_q.push_back({model_view(NREGS2), model_view(NREGS)});
      if (reset) begin
         m_page = 0;
         m_run  = 0;
         m_prev = 1'b0;
         for (int i = 0; i < NREGS; i++) m_snap[i] = '0;
      end else begin
         step = SWI[1] && !m_prev && !SWI[0];
         adv  = step;
         if (SWI[0]) begin
            m_run++;
            if (m_run % SCROLL_DIV == 0) adv = 1'b1;
         end else begin
            m_run = 0;
         end
         if (adv) m_page = SWI[3] ? (m_page + NPAGES - 1) % NPAGES : (m_page + 1) % NPAGES;
         m_prev = SWI[1];
         if (!SWI[2]) for (int i = 0; i < NREGS; i++) m_snap[i] = regs[i];
      end
   endtask

   task automatic tick();
      model_edge();
      @(negedge clk_2);
   endtask

   // Monitor: one expected entry per active edge.
   initial begin
      logic [2*W-1:0] e;
      forever begin
         @(posedge clk_2);
         #1;
         if (exp_q.size() == 0) begin
            if (running) cmp("sb_empty", 64'(exp_q.size()), 64'd1);
         end else begin
            e = exp_q.pop_front();
            cmp("led20",   64'(led2),  64'(e[287:280]));
            cmp("seg20",   64'(seg2),  64'(e[279:272]));
            cmp("lcd_a20", lcd_a2,     e[271:208]);
            cmp("lcd_b20", lcd_b2,     e[207:144]);
            cmp("led",     64'(led1),  64'(e[143:136]));
            cmp("seg",     64'(seg1),  64'(e[135:128]));
            cmp("lcd_a",   lcd_a1,     e[127:64]);
            cmp("lcd_b",   lcd_b1,     e[63:0]);
         end
      end
   end

   initial begin
      seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      reset  = 1'b1;
      SWI    = '0;
      for (int i = 0; i < NREGS; i++) regs[i] = 8'(i * 17);
      m_page = 0;
      m_run  = 0;
      m_prev = 1'b0;
      for (int i = 0; i < NREGS; i++) m_snap[i] = '0;
      running = 1'b1;

      tick();
      tick();
      cmp("rst_lcd_a", lcd_a1, 64'h0);
      cmp("rst_seg", 64'(seg1), 64'h00);
      reset = 1'b0;
      repeat (3) tick();
      cmp("p0_lcd_a", lcd_a1, 64'h0011223344556677);
      cmp("p0_lcd_b", lcd_b1, 64'h8899AABBCCDDEEFF);
      cmp("p0_led", 64'(led1), 64'h00);
      cmp("p0_seg", 64'(seg1), 64'h3F);

      // Held step produces a single advance.
      SWI[1] = 1'b1;
      repeat (5) tick();
      SWI[1] = 1'b0;
      tick();
      cmp("p1_lcd_a", lcd_a1, 64'h1021324354657687);
      cmp("p1_lcd_b", lcd_b1, 64'h98A9BACBDCEDFE0F);
      cmp("p1_led", 64'(led1), 64'h01);
      cmp("p1_seg", 64'(seg1), 64'h06);
      cmp("n20_lcd_a", lcd_a2, 64'h1021324300000000);
      cmp("n20_lcd_b", lcd_b2, 64'h0);
      SWI[1] = 1'b1;
      repeat (2) tick();
      SWI[1] = 1'b0;
      tick();
      cmp("wrap_lcd_a", lcd_a1, 64'h0011223344556677);

      // Freeze holds the snapshot; release shows new data two edges later.
      SWI = 8'h04;
      tick();
      regs[0] = 8'hAA;
      repeat (3) tick();
      cmp("frz_byte", 64'(lcd_a1[63:56]), 64'h00);
      cmp("frz_seg7", 64'(seg1[7]), 64'h1);
      cmp("frz_led6", 64'(led1[6]), 64'h1);
      SWI = 8'h00;
      tick();
      cmp("thaw_1edge", 64'(lcd_a1[63:56]), 64'h00);
      tick();
      cmp("thaw_2edge", 64'(lcd_a1[63:56]), 64'hAA);

      // Down-step from page 0 wraps to the last page.
      SWI = 8'h08;
      tick();
      SWI = 8'h0A;
      repeat (2) tick();
      SWI = 8'h08;
      tick();
      cmp("down_led", 64'(led1), 64'h01);

      // Auto mode with ignored step toggles.
      SWI = 8'h01;
      for (int n = 0; n < 40; n++) begin
         SWI[1] = 1'($urandom_range(0, 1));
         tick();
      end
      SWI[1] = 1'b0;
      for (int n = 0; n < 20 && (m_run % SCROLL_DIV != 10); n++) tick();
      reset = 1'b1;
      tick();
      cmp("arst_lcd_a", lcd_a1, 64'h0);
      cmp("arst_led", 64'(led1), 64'h00);
      reset = 1'b0;
      repeat (16) tick();
      cmp("arst_16", 64'(led1), 64'h80);
      tick();
      cmp("arst_17", 64'(led1), 64'h81);

      // Random traffic.
      for (int n = 0; n < 800; n++) begin
         reset = ($urandom_range(0, 99) < 2);
         if ($urandom_range(0, 39) == 0) SWI[0] = ~SWI[0];
         if ($urandom_range(0, 3) == 0) SWI[1] = ~SWI[1];
         if ($urandom_range(0, 31) == 0) SWI[2] = ~SWI[2];
         if ($urandom_range(0, 15) == 0) SWI[3] = ~SWI[3];
         SWI[7:4] = 4'($urandom);
         if ($urandom_range(0, 2) == 0) regs[$urandom_range(0, NREGS - 1)] = 8'($urandom);
         tick();
      end

      running = 1'b0;
      cmp("sb_drain", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
